// File: rtl/tlb_mmu.sv
// tlb_mmu
// -------
// Fully associative joint TLB (MIPS32 style) that forms the MMU side of the
// CP0 <-> MMU interface. It holds TLBNUM page-table entries. Each entry has
// VPN2, ASID, G, and an even/odd pair of PFN, C, D and V fields.
//
// The block provides:
//   - TLBWI writes at the clock edge.
//   - Combinational TLBR reads and TLBP probes.
//   - Two combinational translation ports:
//       s0 = instruction fetch
//       s1 = data access, or the probe key while tlbp is high
//
// Optional feature (macro TLB_TLBWR_EN):
//   defined   - a free-running random index is implemented, and tlbwr
//               writes entry[random].
//   undefined - random is tied to 0 and tlbwr is ignored.
//
// Ports:
//   clk, rst                  clock; asynchronous active-low reset
//   tlbwi, tlbwr, tlbp        CP0 TLB operation strobes
//   CP0_*                     entry image, index and current ASID from CP0
//   MMU_s1found, MMU_index    probe result
//   MMU_*                     TLBR read-back of entry[CP0_index]
//   inst_vaddr -> inst_*      fetch translation and exception flags
//   data_vaddr, data_req,
//   data_wr -> data_*         data translation and exception flags
//   random                    current random replacement index
module tlb_mmu #(
    parameter int TLBNUM = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      tlbwi,
    input  logic                      tlbwr,
    input  logic                      tlbp,
    input  logic [$clog2(TLBNUM)-1:0] CP0_index,
    input  logic [18:0]               CP0_vpn2,
    input  logic [7:0]                CP0_asid,
    input  logic [19:0]               CP0_pfn0,
    input  logic [19:0]               CP0_pfn1,
    input  logic [2:0]                CP0_c0,
    input  logic [2:0]                CP0_c1,
    input  logic                      CP0_d0,
    input  logic                      CP0_d1,
    input  logic                      CP0_v0,
    input  logic                      CP0_v1,
    input  logic                      CP0_g0,
    input  logic                      CP0_g1,
    output logic                      MMU_s1found,
    output logic [$clog2(TLBNUM)-1:0] MMU_index,
    output logic [18:0]               MMU_vpn2,
    output logic [7:0]                MMU_asid,
    output logic [19:0]               MMU_pfn0,
    output logic [19:0]               MMU_pfn1,
    output logic [2:0]                MMU_c0,
    output logic [2:0]                MMU_c1,
    output logic                      MMU_d0,
    output logic                      MMU_d1,
    output logic                      MMU_v0,
    output logic                      MMU_v1,
    output logic                      MMU_g0,
    output logic                      MMU_g1,
    input  logic [31:0]               inst_vaddr,
    output logic [31:0]               inst_paddr,
    output logic                      inst_uncached,
    output logic                      inst_refill,
    output logic                      inst_invalid,
    input  logic [31:0]               data_vaddr,
    input  logic                      data_req,
    input  logic                      data_wr,
    output logic [31:0]               data_paddr,
    output logic                      data_uncached,
    output logic                      data_refill,
    output logic                      data_invalid,
    output logic                      data_modified,
    output logic [$clog2(TLBNUM)-1:0] random
);

    localparam int IW = $clog2(TLBNUM);

    // The "clean" flag means the page is valid but not dirty.
    // Only a store turns it into a modified exception.
    typedef struct packed {
        logic [31:0] paddr;
        logic        uncached;
        logic        refill;
        logic        invalid;
        logic        clean;
    } xlate_t;

    logic [18:0] vpn2_q [TLBNUM];
    logic [7:0]  asid_q [TLBNUM];
    logic        g_q    [TLBNUM];
    logic [19:0] pfn0_q [TLBNUM];
    logic [19:0] pfn1_q [TLBNUM];
    logic [2:0]  c0_q   [TLBNUM];
    logic [2:0]  c1_q   [TLBNUM];
    logic        d0_q   [TLBNUM];
    logic        d1_q   [TLBNUM];
    logic        v0_q   [TLBNUM];
    logic        v1_q   [TLBNUM];

    logic          wr_en;
    logic [IW-1:0] wr_idx;

`ifdef TLB_TLBWR_EN
    logic [IW-1:0] random_q;

    // Free-running replacement pointer.
    // It counts down and wraps from 0 back to the top entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            random_q <= IW'(TLBNUM - 1);
        else if (random_q == '0)
            random_q <= IW'(TLBNUM - 1);
        else
            random_q <= random_q - 1'b1;
    end

    assign random = random_q;
    // tlbwi takes priority, so a simultaneous tlbwr only writes CP0_index.
    assign wr_en  = tlbwi | tlbwr;
    assign wr_idx = tlbwi ? CP0_index : random_q;
`else
    logic unused_tlbwr;

    assign unused_tlbwr = tlbwr;
    assign random       = '0;
    assign wr_en        = tlbwi;
    assign wr_idx       = CP0_index;
`endif

    // Entry storage.
    // A single G bit is kept: the entry is global only if both halves are.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLBNUM; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                g_q[i]    <= 1'b0;
                pfn0_q[i] <= '0;
                pfn1_q[i] <= '0;
                c0_q[i]   <= '0;
                c1_q[i]   <= '0;
                d0_q[i]   <= 1'b0;
                d1_q[i]   <= 1'b0;
                v0_q[i]   <= 1'b0;
                v1_q[i]   <= 1'b0;
            end
        end else if (wr_en) begin
            vpn2_q[wr_idx] <= CP0_vpn2;
            asid_q[wr_idx] <= CP0_asid;
            g_q[wr_idx]    <= CP0_g0 & CP0_g1;
            pfn0_q[wr_idx] <= CP0_pfn0;
            pfn1_q[wr_idx] <= CP0_pfn1;
            c0_q[wr_idx]   <= CP0_c0;
            c1_q[wr_idx]   <= CP0_c1;
            d0_q[wr_idx]   <= CP0_d0;
            d1_q[wr_idx]   <= CP0_d1;
            v0_q[wr_idx]   <= CP0_v0;
            v1_q[wr_idx]   <= CP0_v1;
        end
    end

    // Associative search.
    // Scanning from the top down lets the lowest matching index win.
    // The returned value is {hit, index}.
    function automatic logic [IW:0] search(input logic [18:0] key);
        logic [IW:0] res;
        res = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (vpn2_q[i] == key && (g_q[i] || asid_q[i] == CP0_asid))
                res = {1'b1, IW'(i)};
        end
        return res;
    endfunction

    // Segment decode plus the page lookup.
    // kseg0/kseg1 share vaddr[31:30] == 2'b10, and bit 29 selects uncached.
    function automatic xlate_t translate(input logic [31:0] vaddr,
                                         input logic hit,
                                         input logic [IW-1:0] idx);
        xlate_t     r;
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        r   = '0;
        pfn = vaddr[12] ? pfn1_q[idx] : pfn0_q[idx];
        c   = vaddr[12] ? c1_q[idx]   : c0_q[idx];
        d   = vaddr[12] ? d1_q[idx]   : d0_q[idx];
        v   = vaddr[12] ? v1_q[idx]   : v0_q[idx];
        if (vaddr[31:30] == 2'b10) begin
            r.paddr    = {3'b000, vaddr[28:0]};
            r.uncached = vaddr[29];
        end else if (!hit) begin
            r.refill = 1'b1;
        end else begin
            r.paddr    = {pfn, vaddr[11:0]};
            r.uncached = (c != 3'd3);
            r.invalid  = !v;
            r.clean    = v && !d;
        end
        return r;
    endfunction

    logic [IW:0]  s0_res;
    logic [IW:0]  s1_res;
    logic [18:0]  s1_key;
    xlate_t       s0_x;
    xlate_t       s1_x;

    // Both translation ports.
    // While probing, the s1 key comes from CP0 and the data exceptions are
    // suppressed so that TLBP never traps.
    always_comb begin
        s1_key = tlbp ? CP0_vpn2 : data_vaddr[31:13];
        s0_res = search(inst_vaddr[31:13]);
        s1_res = search(s1_key);
        s0_x   = translate(inst_vaddr, s0_res[IW], s0_res[IW-1:0]);
        s1_x   = translate(data_vaddr, s1_res[IW], s1_res[IW-1:0]);
    end

    assign inst_paddr    = s0_x.paddr;
    assign inst_uncached = s0_x.uncached;
    assign inst_refill   = s0_x.refill;
    assign inst_invalid  = s0_x.invalid;

    assign data_paddr    = s1_x.paddr;
    assign data_uncached = s1_x.uncached;
    assign data_refill   = s1_x.refill  & data_req & !tlbp;
    assign data_invalid  = s1_x.invalid & data_req & !tlbp;
    assign data_modified = s1_x.clean   & data_wr & data_req & !tlbp;

    assign MMU_s1found = s1_res[IW];
    assign MMU_index   = s1_res[IW-1:0];

    assign MMU_vpn2 = vpn2_q[CP0_index];
    assign MMU_asid = asid_q[CP0_index];
    assign MMU_g0   = g_q[CP0_index];
    assign MMU_g1   = g_q[CP0_index];
    assign MMU_pfn0 = pfn0_q[CP0_index];
    assign MMU_pfn1 = pfn1_q[CP0_index];
    assign MMU_c0   = c0_q[CP0_index];
    assign MMU_c1   = c1_q[CP0_index];
    assign MMU_d0   = d0_q[CP0_index];
    assign MMU_d1   = d1_q[CP0_index];
    assign MMU_v0   = v0_q[CP0_index];
    assign MMU_v1   = v1_q[CP0_index];

endmodule
